// File: rtl/core_ctrl_pkg.sv
// Shared layout of the decoded MIPS control bundle so that decode, ID/EX and EX
// agree on field positions and on what a bubble looks like.
package core_ctrl_pkg;

  localparam int CTRL_W = 11;

  // Bundle layout, MSB first: {RegDst, ALUSrc, MemToReg, RegWrite, MemWrite,
  // MemRead, Branch, Jump, ExtOp, ALUOp[1:0]}
  localparam int REG_DST_BIT    = 10;
  localparam int ALU_SRC_BIT    = 9;
  localparam int MEM_TO_REG_BIT = 8;
  localparam int REG_WRITE_BIT  = 7;
  localparam int MEM_WRITE_BIT  = 6;
  localparam int MEM_READ_BIT   = 5;
  localparam int BRANCH_BIT     = 4;
  localparam int JUMP_BIT       = 3;
  localparam int EXT_OP_BIT     = 2;
  localparam int ALU_OP_LSB     = 0;
  localparam int ALU_OP_W       = 2;

  typedef logic [CTRL_W-1:0] ctrl_t;

  localparam ctrl_t CTRL_NOP = '0;

  // True when the bundle can change architectural state (register file or memory).
  function automatic logic ctrlWritesState(input ctrl_t ctrl);
    return ctrl[REG_WRITE_BIT] | ctrl[MEM_WRITE_BIT];
  endfunction

endpackage

// File: rtl/bubble_counter.sv
// Bubble-run down-counter for the ID/EX stage: decides when a bubble is written,
// drives the upstream stall, and keeps a saturating count of inserted bubbles.
module bubble_counter #(
  parameter int CNT_W  = 3,
  parameter int PERF_W = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              hold_i,
  input  logic              flush_i,
  input  logic              start_i,
  input  logic [CNT_W-1:0]  len_i,
  output logic              stall_o,
  output logic              bubble_o,
  output logic [CNT_W-1:0]  cnt_o,
  output logic [PERF_W-1:0] total_o
);
  import core_ctrl_pkg::*;

  logic [CNT_W-1:0]  cntReg, cntNext;
  logic [PERF_W-1:0] totalReg, totalNext;
  logic              runActive;
  logic              startOk;

  assign runActive = (cntReg != '0);
  // A new run is only accepted once the previous one has fully drained.
  assign startOk   = start_i & ~runActive & (len_i != '0);
  assign stall_o   = ~flush_i & (runActive | startOk);

  always_comb begin
    cntNext  = cntReg;
    bubble_o = 1'b0;
    if (flush_i) begin
      cntNext  = '0;
      bubble_o = 1'b1;
    end else if (hold_i) begin
      cntNext  = cntReg;
    end else if (startOk) begin
      cntNext  = len_i - 1'b1;
      bubble_o = 1'b1;
    end else if (runActive) begin
      cntNext  = cntReg - 1'b1;
      bubble_o = 1'b1;
    end
  end

  assign totalNext = (bubble_o && (totalReg != '1)) ? totalReg + 1'b1 : totalReg;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cntReg   <= '0;
      totalReg <= '0;
    end else begin
      cntReg   <= cntNext;
      totalReg <= totalNext;
    end
  end

  assign cnt_o   = cntReg;
  assign total_o = totalReg;

endmodule

// File: rtl/id_ex_ctrl_stage.sv
// ID/EX control-bundle register with freeze, single-bubble flush and counted
// multi-cycle bubble injection.
module id_ex_ctrl_stage #(
  parameter int                 CTRL_W    = core_ctrl_pkg::CTRL_W,
  parameter logic [CTRL_W-1:0]  NOP_VALUE = {CTRL_W{1'b0}},
  parameter int                 CNT_W     = 3,
  parameter int                 PERF_W    = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  input  logic              valid_i,
  input  logic              hold_i,
  input  logic              flush_i,
  input  logic              bubble_start_i,
  input  logic [CNT_W-1:0]  bubble_len_i,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic              valid_o,
  output logic              stall_o,
  output logic [CNT_W-1:0]  bubble_cnt_o,
  output logic [PERF_W-1:0] bubble_total_o
);
  import core_ctrl_pkg::*;

  logic [CTRL_W-1:0] ctrlReg;
  logic              validReg;
  logic              bubble;

  bubble_counter #(
    .CNT_W  (CNT_W),
    .PERF_W (PERF_W)
  ) uBubbleCounter (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .hold_i   (hold_i),
    .flush_i  (flush_i),
    .start_i  (bubble_start_i),
    .len_i    (bubble_len_i),
    .stall_o  (stall_o),
    .bubble_o (bubble),
    .cnt_o    (bubble_cnt_o),
    .total_o  (bubble_total_o)
  );

  // bubble already encodes flush-over-hold priority, so hold only gates passthrough.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ctrlReg  <= NOP_VALUE;
      validReg <= 1'b0;
    end else if (bubble) begin
      ctrlReg  <= NOP_VALUE;
      validReg <= 1'b0;
    end else if (!hold_i) begin
      ctrlReg  <= ctrl_i;
      validReg <= valid_i;
    end
  end

  assign ctrl_o  = ctrlReg;
  assign valid_o = validReg;

endmodule

// File: tb/tb_id_ex_ctrl_stage.sv
// Randomised bench for id_ex_ctrl_stage: a run-level reference model is checked
// against the DUT every cycle, with a few hand-derived literal checkpoints.
module tb_id_ex_ctrl_stage;

  localparam int CTRL_W = 11;
  localparam int CNT_W  = 3;
  localparam int PERF_W = 4;
  localparam int SAT    = (1 << PERF_W) - 1;

  logic              clk_i = 1'b0;
  logic              rst_i = 1'b1;
  logic [CTRL_W-1:0] ctrl_i = '0;
  logic              valid_i = 1'b0;
  logic              hold_i = 1'b0;
  logic              flush_i = 1'b0;
  logic              bubble_start_i = 1'b0;
  logic [CNT_W-1:0]  bubble_len_i = '0;
  logic [CTRL_W-1:0] ctrl_o;
  logic              valid_o;
  logic              stall_o;
  logic [CNT_W-1:0]  bubble_cnt_o;
  logic [PERF_W-1:0] bubble_total_o;

  int nCompared = 0;
  int nMismatched = 0;

  // Reference state: last bundle handed to EX, bubbles still owed, bubbles ever written.
  logic [CTRL_W-1:0] mCtrl = '0;
  logic              mValid = 1'b0;
  int                mOwed = 0;
  int                mBubbles = 0;

  id_ex_ctrl_stage #(
    .CTRL_W    (CTRL_W),
    .NOP_VALUE ({CTRL_W{1'b0}}),
    .CNT_W     (CNT_W),
    .PERF_W    (PERF_W)
  ) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .ctrl_i         (ctrl_i),
    .valid_i        (valid_i),
    .hold_i         (hold_i),
    .flush_i        (flush_i),
    .bubble_start_i (bubble_start_i),
    .bubble_len_i   (bubble_len_i),
    .ctrl_o         (ctrl_o),
    .valid_o        (valid_o),
    .stall_o        (stall_o),
    .bubble_cnt_o   (bubble_cnt_o),
    .bubble_total_o (bubble_total_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input longint act, input longint exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a run of N is N owed bubbles, each consumed by one unheld edge.
  initial forever begin
    @(posedge clk_i or posedge rst_i);
    if (rst_i) begin
      mCtrl = '0; mValid = 1'b0; mOwed = 0; mBubbles = 0;
    end else if (flush_i) begin
      mCtrl = '0; mValid = 1'b0; mOwed = 0; mBubbles++;
    end else if (!hold_i) begin
      if (mOwed == 0 && bubble_start_i && bubble_len_i != 0) mOwed = int'(bubble_len_i);
      if (mOwed > 0) begin
        mCtrl = '0; mValid = 1'b0; mOwed--; mBubbles++;
      end else begin
        mCtrl = ctrl_i; mValid = valid_i;
      end
    end
  end

  always @(negedge clk_i) begin
    #2;
    check("ctrl_o", ctrl_o, mCtrl);
    check("valid_o", valid_o, mValid);
    check("bubble_cnt_o", bubble_cnt_o, mOwed);
    check("bubble_total_o", bubble_total_o, (mBubbles > SAT) ? SAT : mBubbles);
    check("stall_o", stall_o,
          !flush_i && (mOwed != 0 || (bubble_start_i && bubble_len_i != 0)));
  end

  task automatic drive(input logic [CTRL_W-1:0] c, input logic v, input logic h,
                       input logic f, input logic s, input logic [CNT_W-1:0] l);
    @(negedge clk_i);
    rst_i = 1'b0;
    ctrl_i = c; valid_i = v; hold_i = h; flush_i = f; bubble_start_i = s; bubble_len_i = l;
  endtask

  task automatic idle(input logic [CTRL_W-1:0] c);
    drive(c, 1'b1, 1'b0, 1'b0, 1'b0, '0);
  endtask

  initial begin
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
    #3;
    check("reset ctrl_o", ctrl_o, 0);
    check("reset valid_o", valid_o, 0);
    check("reset total", bubble_total_o, 0);
    check("reset stall", stall_o, 0);

    // Passthrough with one cycle of latency
    idle(11'h5A3);
    idle(11'h5A3); #3;
    check("pass ctrl_o", ctrl_o, 11'h5A3);
    check("pass valid_o", valid_o, 1);
    check("pass stall", stall_o, 0);
    check("pass total", bubble_total_o, 0);
    idle(11'h5A3);

    // Run of 3: stall for exactly three cycles, counter 2,1,0
    drive(11'h123, 1'b1, 1'b0, 1'b0, 1'b1, 3'd3); #3;
    check("run3 stall0", stall_o, 1);
    idle(11'h321); #3;
    check("run3 cnt2", bubble_cnt_o, 2);
    check("run3 nop", ctrl_o, 0);
    check("run3 stall1", stall_o, 1);
    idle(11'h321); #3;
    check("run3 cnt1", bubble_cnt_o, 1);
    check("run3 stall2", stall_o, 1);
    idle(11'h321); #3;
    check("run3 cnt0", bubble_cnt_o, 0);
    check("run3 stall_end", stall_o, 0);
    check("run3 total", bubble_total_o, 3);
    idle(11'h321); #3;
    check("run3 resume", ctrl_o, 11'h321);
    check("run3 resume valid", valid_o, 1);

    // Run of 4 with a two-cycle freeze in the middle
    drive(11'h0AA, 1'b1, 1'b0, 1'b0, 1'b1, 3'd4);
    idle(11'h0AB);
    drive(11'h0AC, 1'b1, 1'b1, 1'b0, 1'b0, '0);
    drive(11'h0AC, 1'b1, 1'b1, 1'b0, 1'b0, '0);
    repeat (4) idle(11'h0AD);

    // Flush when two bubbles remain, then flush during hold
    drive(11'h111, 1'b1, 1'b0, 1'b0, 1'b1, 3'd4);
    idle(11'h112);
    drive(11'h113, 1'b1, 1'b0, 1'b1, 1'b0, '0); #3;
    check("flush stall", stall_o, 0);
    idle(11'h114); #3;
    check("flush cnt", bubble_cnt_o, 0);
    drive(11'h115, 1'b1, 1'b0, 1'b0, 1'b1, 3'd3);
    drive(11'h116, 1'b1, 1'b1, 1'b1, 1'b0, '0);
    idle(11'h117);

    // Zero-length request and a restart attempt mid-run
    drive(11'h222, 1'b1, 1'b0, 1'b0, 1'b1, 3'd0); #3;
    check("len0 stall", stall_o, 0);
    drive(11'h223, 1'b1, 1'b0, 1'b0, 1'b1, 3'd2);
    drive(11'h224, 1'b1, 1'b0, 1'b0, 1'b1, 3'd7);
    repeat (3) idle(11'h225);

    // Random traffic with occasional asynchronous reset pulses
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 99) < 2) begin
        drive(11'($urandom_range(0, 2047)), 1'b1, 1'b0, 1'b0, 1'b0, '0);
        #4 rst_i = 1'b1;
        #1;
        check("async rst ctrl_o", ctrl_o, 0);
        check("async rst valid_o", valid_o, 0);
        check("async rst cnt", bubble_cnt_o, 0);
        check("async rst total", bubble_total_o, 0);
        check("async rst stall", stall_o, 0);
      end else begin
        drive(11'($urandom_range(0, 2047)), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 99) < 15), 1'($urandom_range(0, 99) < 8),
              1'($urandom_range(0, 99) < 25), 3'($urandom_range(0, 7)));
      end
    end

    // Saturation: 21 more bubbles must pin the 4-bit total at 15
    idle(11'h333);
    for (int r = 0; r < 3; r++) begin
      drive(11'h334, 1'b1, 1'b0, 1'b0, 1'b1, 3'd7);
      repeat (7) idle(11'h335);
    end
    #3;
    check("saturated total", bubble_total_o, SAT);
    idle(11'h336);
    #3;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule

// File: doc/id_ex_ctrl_stage.md
Name: id_ex_ctrl_stage

Overview:
- Parametrised ID/EX control-bundle pipeline register for the MIPS core; supersedes the combinational stall-zeroing of control signals.
- Registers the decoded control bundle and supports a freeze (hold), a flush (single bubble), and multi-cycle bubble injection driven by an internal down-counter.
- Drives stall_o back to PC/IF-ID while injecting, and keeps a saturating count of bubbles inserted for performance visibility.

Parameters:
- CTRL_W, 11, width of the control bundle {RegDst, ALUSrc, MemToReg, RegWrite, MemWrite, MemRead, Branch, Jump, ExtOp, ALUOp[1:0]}.
- NOP_VALUE, {CTRL_W{1'b0}}, bundle value driven during a bubble.
- CNT_W, 3, width of the bubble length and down-counter; maximum run is 2^CNT_W-1.
- PERF_W, 16, width of the saturating bubble counter.

Ports:
- clk_i  in  1  clock; all state changes on the rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- ctrl_i  in  CTRL_W  decoded control bundle from ID.
- valid_i  in  1  ID holds a real instruction.
- hold_i  in  1  downstream freeze; stage and counter keep their values.
- flush_i  in  1  squash (branch/jump taken); inject one bubble and cancel any pending run.
- bubble_start_i  in  1  request a run of bubbles (load-use, multi-cycle op).
- bubble_len_i  in  CNT_W  number of bubbles requested; sampled only when a start is accepted.
- ctrl_o  out  CTRL_W  registered bundle to EX.
- valid_o  out  1  registered valid to EX.
- stall_o  out  1  combinational; upstream must hold PC and IF/ID while high.
- bubble_cnt_o  out  CNT_W  bubbles remaining in the current run.
- bubble_total_o  out  PERF_W  saturating count of bubbles written into the stage.

Behaviour:
- Reset (async, rst_i=1): ctrl_o=NOP_VALUE, valid_o=0, cnt=0, bubble_total_o=0. stall_o then follows the combinational rule below, so it is 0 unless a start with nonzero length is presented.
- Internal signal start_ok = bubble_start_i & (cnt==0) & (bubble_len_i!=0).
- stall_o = (cnt!=0) | start_ok. It is independent of hold_i and is forced to 0 while flush_i=1.
- Per rising edge, evaluated in priority order:
  1. flush_i=1: ctrl_o<=NOP_VALUE, valid_o<=0, cnt<=0, bubble_total +1. Flush overrides hold_i.
  2. hold_i=1: all registers keep their value, including cnt and bubble_total. A start presented during hold is not accepted; the requester must keep it asserted.
  3. start_ok=1: ctrl_o<=NOP_VALUE, valid_o<=0, cnt<=bubble_len_i-1, bubble_total +1.
  4. cnt!=0: ctrl_o<=NOP_VALUE, valid_o<=0, cnt<=cnt-1, bubble_total +1.
  5. Otherwise: ctrl_o<=ctrl_i, valid_o<=valid_i.
- Latency is 1 cycle from ctrl_i to ctrl_o. A run of length N produces exactly N consecutive bubble cycles, excluding held cycles, with stall_o high for those same N cycles.
- bubble_start_i while cnt!=0 is ignored; runs do not extend or stack.
- bubble_len_i=0 has no effect and stall_o stays 0.
- bubble_total saturates at 2^PERF_W-1 and never wraps.
- Reset asserted mid-run clears the run immediately; no residual stall after release.
- Arithmetic is unsigned. cnt-1 is never evaluated at 0 because branch 4 requires cnt!=0.

Decomposition:
- Shared package/include (core_ctrl_pkg): CTRL_W, the bit-position constants of each control field within the bundle, and the NOP bundle constant, so decode, this stage and EX agree on layout.
- One natural sub-module: bubble_counter, which holds the down-counter, start_ok/stall_o logic and the saturating perf counter. The top level holds the bundle register and the priority mux.

Test Plan:
- Reset, then ctrl_i=11'h5A3 and valid_i=1 for 3 cycles -> ctrl_o=11'h5A3 and valid_o=1 one cycle later; stall_o=0; bubble_total_o=0.
- bubble_start_i=1 with bubble_len_i=3 for one cycle -> stall_o high for exactly 3 cycles; ctrl_o=0 and valid_o=0 for 3 cycles; bubble_cnt_o goes 2,1,0; bubble_total_o=3; the next cycle passes ctrl_i through.
- Run of length 4 with hold_i=1 for 2 cycles mid-run -> cnt frozen during hold; total bubble cycles still 4; stall_o high for 6 cycles.
- flush_i=1 at the cycle when bubble_cnt_o=2 -> bubble_cnt_o=0 next cycle, stall_o=0, one bubble counted; flush with hold_i=1 still produces a bubble.
- bubble_start_i=1 with len=0 -> stall_o=0 and normal passthrough. A second start during an active run -> ignored, run length unchanged.
- Preload bubble_total to 2^PERF_W-2 (PERF_W=4 build: value 14), then inject a run of 3 -> bubble_total_o saturates at 15. rst_i pulsed mid-run, asynchronously off the clock edge -> all outputs cleared immediately and stall_o=0 after release.
